aes_arbiter: RTL and testbench
==============================

AES_ARBITER -- requirements
Module: aes_arbiter

Interface
REQ-001 Parameter BOOT_CYCLES, default 12: cycles after reset release before the first core start is issued (covers the core's post-reset free-run).
REQ-002 Parameter TIMEOUT, default 16: maximum cycles from aes_start to aes_ready before the operation is aborted with an error.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req0 / req1  input  1  requester 0 / 1 encryption request; level, held until the matching gnt.
REQ-006 pt0 / pt1  input  128  requester plaintext; valid while req is high.
REQ-007 key0 / key1  input  128  requester key; valid while req is high.
REQ-008 gnt0 / gnt1  output  1  one-cycle pulse; operands of that requester latched this cycle.
REQ-009 done0 / done1  output  1  one-cycle pulse; ct_out and err valid for that requester.
REQ-010 ct_out  output  128  ciphertext of the completed operation; held until the next done.
REQ-011 err  output  1  qualified by done0/done1; high means timeout, and ct_out is then all zeros.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 aes_plaintext / aes_key  output  128  registered operands to the AES core.
REQ-014 aes_start  output  1  one-cycle start pulse to the core.
REQ-015 aes_cipher  input  128  core ciphertext.
REQ-016 aes_ready  input  1  core completion pulse.

Function
REQ-017 FSM states SHALL be BOOT, IDLE, GRANT, START, WAIT, DONE.
REQ-018 BOOT SHALL count BOOT_CYCLES cycles, then enter IDLE; requests are ignored in BOOT.
REQ-019 IDLE with any req high SHALL select a winner and enter GRANT next cycle.
REQ-020 With only one req high, that requester SHALL win.
REQ-021 With both req high, the requester not served last SHALL win (round-robin); the last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-022 GRANT SHALL pulse gnt of the winner for one cycle and latch its pt/key into aes_plaintext/aes_key.
REQ-023 GRANT SHALL record the winner as last-served and enter START.
REQ-024 START SHALL drive aes_start high for exactly one cycle, clear the timeout counter and enter WAIT.
REQ-025 aes_plaintext/aes_key SHALL stay constant from GRANT until leaving WAIT.
REQ-026 WAIT SHALL increment the timeout counter each cycle.
REQ-027 In WAIT, on aes_ready: latch aes_cipher into ct_out, clear err, enter DONE.
REQ-028 In WAIT, when the counter reaches TIMEOUT without aes_ready: ct_out=0, err=1, enter DONE.
REQ-029 aes_ready arriving in the same cycle the counter reaches TIMEOUT SHALL be treated as success.
REQ-030 DONE SHALL pulse done of the served requester for one cycle, then return to IDLE.
REQ-031 A requester still holding req after its done SHALL be treated as a new request and arbitrated normally.
REQ-032 Minimum turnaround, IDLE request to done: 4 cycles plus core latency.
REQ-033 aes_ready outside WAIT SHALL be ignored.
REQ-034 Request changes outside IDLE SHALL not affect the current operation.
REQ-035 At most one gnt and one done SHALL be high in any cycle; gnt and done never coincide.
REQ-036 The timeout counter SHALL be wide enough for TIMEOUT without wrap-around, and SHALL saturate.

Reset
REQ-037 Reset SHALL force: state BOOT, boot counter 0, last-served pointer 1.
REQ-038 Reset SHALL force all outputs to 0: gnt0/1, done0/1, err, busy (busy goes to 1 on the first clock in BOOT), aes_start, aes_plaintext, aes_key, ct_out.
REQ-039 Reset asserted mid-operation SHALL abort without any done pulse, and the block SHALL re-run BOOT.

Verification
REQ-040 Single request, FIPS-197 vector: req0, pt0=00112233445566778899aabbccddeeff, key0=000102030405060708090a0b0c0d0e0f after BOOT -> gnt0 once, aes_start once, done0 with ct_out=69c4e0d86a7b0430d8cdb78070b4c55a and err=0.
REQ-041 Contention: req0 and req1 high together, held -> service order 0,1,0,1; every done matches the preceding gnt.
REQ-042 Boot masking: req1 asserted 2 cycles after reset release -> no gnt1 before cycle BOOT_CYCLES; then normal completion.
REQ-043 Timeout: core model never returns aes_ready -> done with err=1 and ct_out=0 exactly TIMEOUT cycles after the WAIT entry cycle; next request is served normally.
REQ-044 Reset mid-WAIT: reset pulse while in WAIT -> all outputs 0, no done pulse, BOOT re-run, pointer back to 1.
REQ-045 Ready/timeout collision: aes_ready in the cycle the counter reaches TIMEOUT -> err=0 and ct_out=aes_cipher.

Source files
------------

// File: rtl/aes_arbiter.sv
// aes_arbiter: shares one AES core between two requesters with round-robin
// arbitration, a post-reset boot hold-off and a completion timeout.
module aes_arbiter #(
    parameter int BOOT_CYCLES = 12,
    parameter int TIMEOUT     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [127:0] pt0,
    input  logic [127:0] pt1,
    input  logic [127:0] key0,
    input  logic [127:0] key1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [127:0] ct_out,
    output logic         err,
    output logic         busy,
    output logic [127:0] aes_plaintext,
    output logic [127:0] aes_key,
    output logic         aes_start,
    input  logic [127:0] aes_cipher,
    input  logic         aes_ready
);
    localparam int BW = $clog2(BOOT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {BOOT, IDLE, GRANT, START, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] boot_q, boot_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          win_q, win_d, last_q, last_d;
    logic [127:0]  pt_q, pt_d, key_q, key_d, ct_q, ct_d;
    logic          err_q, err_d, busy_q;

    always_comb begin
        state_d = state_q;
        boot_d  = boot_q;
        tmo_d   = tmo_q;
        win_d   = win_q;
        last_d  = last_q;
        pt_d    = pt_q;
        key_d   = key_q;
        ct_d    = ct_q;
        err_d   = err_q;
        case (state_q)
            BOOT: begin
                boot_d  = boot_q + BW'(1);
                state_d = (boot_q == BW'(BOOT_CYCLES - 1)) ? IDLE : BOOT;
            end
            IDLE: if (req0 || req1) begin
                // tie goes to whoever was not served last
                win_d   = (req0 && req1) ? !last_q : req1;
                pt_d    = win_d ? pt1 : pt0;
                key_d   = win_d ? key1 : key0;
                state_d = GRANT;
            end
            GRANT: begin
                last_d  = win_q;
                state_d = START;
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                tmo_d = (tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + TW'(1);
                // a ready in the expiring cycle still counts as success
                if (aes_ready) begin
                    ct_d    = aes_cipher;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (tmo_d == TW'(TIMEOUT)) begin
                    ct_d    = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            boot_q  <= '0;
            tmo_q   <= '0;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            pt_q    <= '0;
            key_q   <= '0;
            ct_q    <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
            tmo_q   <= tmo_d;
            win_q   <= win_d;
            last_q  <= last_d;
            pt_q    <= pt_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
            err_q   <= err_d;
            busy_q  <= state_d != IDLE;
        end
    end

    assign gnt0          = state_q == GRANT && !win_q;
    assign gnt1          = state_q == GRANT && win_q;
    assign done0         = state_q == DONE && !win_q;
    assign done1         = state_q == DONE && win_q;
    assign aes_start     = state_q == START;
    assign aes_plaintext = pt_q;
    assign aes_key       = key_q;
    assign ct_out        = ct_q;
    assign err           = err_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_aes_arbiter.sv
// tb_aes_arbiter: directed table, corner sequences and randomized traffic
// against a transaction-level scoreboard with a behavioural AES core stand-in.
module tb_aes_arbiter;
    localparam int BC = 12;
    localparam int T  = 16;
    localparam logic [127:0] FPT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0, reset = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [127:0] pt0 = '0, pt1 = '0, key0 = '0, key1 = '0;
    logic         gnt0, gnt1, done0, done1, err, busy, aes_start;
    logic         aes_ready = 1'b0;
    logic [127:0] ct_out, aes_plaintext, aes_key;
    logic [127:0] aes_cipher = '0;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    aes_arbiter #(.BOOT_CYCLES(BC), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .pt0(pt0), .pt1(pt1), .key0(key0), .key1(key1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .ct_out(ct_out), .err(err), .busy(busy),
        .aes_plaintext(aes_plaintext), .aes_key(aes_key), .aes_start(aes_start),
        .aes_cipher(aes_cipher), .aes_ready(aes_ready)
    );

    function automatic logic [127:0] core_f(input logic [127:0] p, input logic [127:0] k);
        return (p == FPT && k == FKEY) ? FCT : p ^ {k[63:0], k[127:64]} ^ {4{32'h5a3c_96e1}};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Core stand-in: answers core_lat cycles after aes_start (0 = never).
    int           core_lat = 1, cur_lat = 1, cnt = 0;
    bit           spur = 1'b0;
    logic [127:0] ct_c = '0;
    always @(negedge clk) begin
        aes_ready = 1'b0;
        if (reset) cnt = 0;
        else if (aes_start) begin
            cur_lat = core_lat;
            cnt     = core_lat;
            ct_c    = core_f(aes_plaintext, aes_key);
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                aes_ready  = 1'b1;
                aes_cipher = ct_c;
            end
        end else if (spur && !busy && $urandom_range(0, 3) == 0) begin
            aes_ready  = 1'b1;
            aes_cipher = rnd128();
        end
    end

    // Scoreboard: every gnt opens a transaction whose start and done are
    // predicted from the arbitration and timing rules.
    int           cyc = 0, first_gnt = 0, n_done = 0, gnt_cyc = 0, start_cyc = 0, last_who = 3;
    bit           pend_start = 1'b0, pend_done = 1'b0, last_m = 1'b1, g, ok_exp, op_who;
    logic [127:0] op_pt, op_key, ct_m = '0;
    logic         err_m = 1'b0;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            cyc = 0; first_gnt = 0; pend_start = 1'b0; pend_done = 1'b0;
            last_m = 1'b1; last_who = 3; ct_m = '0; err_m = 1'b0;
        end else begin
            cyc++;
            if (gnt0 || gnt1) begin
                g = gnt1;
                chk("gnt_onehot", 128'(gnt0 & gnt1), 128'(0));
                chk("gnt_after_boot", 128'(cyc > BC), 128'(1));
                chk("gnt_has_req", 128'(g ? req1 : req0), 128'(1));
                chk("gnt_round_robin", 128'(g), 128'((req0 && req1) ? !last_m : req1));
                chk("gnt_no_overlap", 128'(pend_start | pend_done), 128'(0));
                chk("gnt_pt", aes_plaintext, g ? pt1 : pt0);
                chk("gnt_key", aes_key, g ? key1 : key0);
                if (first_gnt == 0) first_gnt = cyc;
                last_m = g; op_who = g; op_pt = g ? pt1 : pt0; op_key = g ? key1 : key0;
                gnt_cyc = cyc; pend_start = 1'b1;
            end
            if (aes_start) begin
                chk("start_timing", 128'(pend_start && cyc == gnt_cyc + 1), 128'(1));
                chk("start_pt", aes_plaintext, op_pt);
                chk("start_key", aes_key, op_key);
                pend_start = 1'b0; pend_done = 1'b1; start_cyc = cyc;
            end else if (pend_start && cyc > gnt_cyc + 1) begin
                chk("start_missing", 128'(aes_start), 128'(1));
                pend_start = 1'b0;
            end
            if (done0 || done1) begin
                ok_exp = cur_lat != 0 && cur_lat <= T;
                chk("done_onehot", 128'(done0 & done1), 128'(0));
                chk("done_gnt_overlap", 128'(gnt0 | gnt1), 128'(0));
                chk("done_pending", 128'(pend_done), 128'(1));
                chk("done_who", 128'(done1), 128'(op_who));
                chk("done_cycle", 128'(cyc - start_cyc), 128'(ok_exp ? cur_lat + 1 : T + 1));
                chk("done_err", 128'(err), 128'(!ok_exp));
                chk("done_ct", ct_out, ok_exp ? core_f(op_pt, op_key) : 128'(0));
                pend_done = 1'b0; ct_m = ct_out; err_m = err; last_who = int'(done1); n_done++;
            end else begin
                chk("ct_hold", ct_out, ct_m);
                chk("err_hold", 128'(err), 128'(err_m));
                if (pend_done && cyc > start_cyc + T + 1) begin
                    chk("done_missing", 128'(done0 | done1), 128'(1));
                    pend_done = 1'b0;
                end
            end
        end
    end

    bit hold = 1'b0;
    task automatic step();
        @(negedge clk);
        if (!hold) begin
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
        end
    endtask

    task automatic wait_done(input int lim);
        int n = n_done;
        for (int i = 0; i < lim && n_done == n; i++) step();
        chk("done_seen", 128'(n_done > n), 128'(1));
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && busy; i++) step();
        chk("idle_reached", 128'(busy), 128'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; hold = 1'b0; spur = 1'b0;
        #1;
        chk("rst_gnt", 128'({gnt0, gnt1}), 128'(0));
        chk("rst_done", 128'({done0, done1}), 128'(0));
        chk("rst_err_busy_start", 128'({err, busy, aes_start}), 128'(0));
        chk("rst_pt", aes_plaintext, 128'(0));
        chk("rst_key", aes_key, 128'(0));
        chk("rst_ct", ct_out, 128'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit r0, r1;
        int lat;
        bit who, e;
    } vec_t;
    vec_t tv[8];
    logic [127:0] tp0[8], tk0[8], tp1[8], tk1[8];
    int rr_exp[5] = '{0, 1, 0, 1, 0};

    initial begin
        tv[0] = '{1'b1, 1'b0, 3,     1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b1, 2,     1'b1, 1'b0};
        tv[2] = '{1'b1, 1'b1, 5,     1'b0, 1'b0};
        tv[3] = '{1'b1, 1'b1, 1,     1'b1, 1'b0};
        tv[4] = '{1'b0, 1'b1, 0,     1'b1, 1'b1};
        tv[5] = '{1'b1, 1'b0, T,     1'b0, 1'b0};
        tv[6] = '{1'b0, 1'b1, T + 1, 1'b1, 1'b1};
        tv[7] = '{1'b1, 1'b1, 0,     1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            tp0[i] = rnd128(); tk0[i] = rnd128(); tp1[i] = rnd128(); tk1[i] = rnd128();
        end
        tp0[0] = FPT; tk0[0] = FKEY;

        // reset values, then boot masking with a late req1
        do_reset();
        step();
        chk("boot_busy", 128'(busy), 128'(1));
        step();
        pt1 = rnd128(); key1 = rnd128(); core_lat = 4; req1 = 1'b1;
        wait_done(BC + 40);
        chk("boot_first_gnt", 128'(first_gnt), 128'(BC + 1));
        step();
        chk("idle_busy", 128'(busy), 128'(0));

        // directed vectors: FIPS-197, ties, timeouts, ready/timeout collision
        for (int i = 0; i < 8; i++) begin
            wait_idle(40);
            core_lat = tv[i].lat;
            pt0 = tp0[i]; key0 = tk0[i]; pt1 = tp1[i]; key1 = tk1[i];
            req0 = tv[i].r0; req1 = tv[i].r1;
            wait_done(60);
            req0 = 1'b0; req1 = 1'b0;
            chk($sformatf("tv%0d_who", i), 128'(last_who), 128'(tv[i].who));
            chk($sformatf("tv%0d_err", i), 128'(err), 128'(tv[i].e));
            chk($sformatf("tv%0d_ct", i), ct_out,
                tv[i].e ? 128'(0) : core_f(tv[i].who ? tp1[i] : tp0[i], tv[i].who ? tk1[i] : tk0[i]));
        end

        // held contention: 0,1,0,1, then a still-held req0 is served again
        do_reset();
        hold = 1'b1; core_lat = 2;
        pt0 = rnd128(); key0 = rnd128(); pt1 = rnd128(); key1 = rnd128();
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) req1 = 1'b0;
            wait_done(BC + 40);
            chk($sformatf("hold_order%0d", i), 128'(last_who), 128'(rr_exp[i]));
        end
        hold = 1'b0; req0 = 1'b0;

        // reset while waiting on the core
        do_reset();
        core_lat = 0; pt0 = rnd128(); key0 = rnd128(); req0 = 1'b1;
        for (int i = 0; i < BC + 20 && !pend_done; i++) step();
        chk("midwait_started", 128'(pend_done), 128'(1));
        repeat (3) step();
        do_reset();
        core_lat = 3; pt0 = rnd128(); pt1 = rnd128(); req0 = 1'b1; req1 = 1'b1;
        wait_done(BC + 40);
        req0 = 1'b0; req1 = 1'b0;
        chk("midwait_reboot", 128'(first_gnt), 128'(BC + 1));
        chk("midwait_ptr_reset", 128'(last_who), 128'(0));

        // randomized traffic with stray ready pulses while idle
        spur = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            core_lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, T + 2));
            if (!req0 && $urandom_range(0, 3) == 0) begin
                pt0 = rnd128(); key0 = rnd128(); req0 = 1'b1;
            end
            if (!req1 && $urandom_range(0, 3) == 0) begin
                pt1 = rnd128(); key1 = rnd128(); req1 = 1'b1;
            end
        end
        req0 = 1'b0; req1 = 1'b0; spur = 1'b0;
        repeat (T + 8) step();
        wait_idle(60);
        chk("rand_progress", 128'(n_done > 100), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
